multicycle_control_unit: RTL



---
 rtl/multicycle_control_unit_if.sv | 41 ++++
 rtl/multicycle_control_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit_if.sv
// Control/datapath bundle for the multicycle control unit: instruction-register opcode and
// memory handshake in, datapath strobes, selects and status out.
interface multicycle_control_unit_if #(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned ALUOP_W  = 3,
    parameter int unsigned CNT_W    = 16
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                pc_write;
    logic                pc_write_cond;
    logic                ir_write;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                reg_dst;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          pc_source;
    logic [ALUOP_W-1:0]  alu_op;
    logic [3:0]          state;
    logic                illegal_op;
    logic                instr_done;
    logic [CNT_W-1:0]    instr_count;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_op, state,
               illegal_op, instr_done, instr_count
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_op, state,
               illegal_op, instr_done, instr_count
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/write-back sequencing with
// memory-ready stalls, retired-instruction counter and illegal-opcode flag.
module multicycle_control_unit #(
    parameter int unsigned         OPCODE_W    = 6,
    parameter int unsigned         ALUOP_W     = 3,
    parameter int unsigned         CNT_W       = 16,
    parameter logic [OPCODE_W-1:0] OP_RTYPE    = 6'b000000,
    parameter logic [OPCODE_W-1:0] OP_ADDI     = 6'b000001,
    parameter logic [OPCODE_W-1:0] OP_LW       = 6'b000100,
    parameter logic [OPCODE_W-1:0] OP_SW       = 6'b000101,
    parameter logic [OPCODE_W-1:0] OP_BEQ      = 6'b000110,
    parameter logic [OPCODE_W-1:0] OP_IALU_LO  = 6'b000010,
    parameter logic [OPCODE_W-1:0] OP_IALU_HI  = 6'b000011,
    parameter logic [ALUOP_W-1:0]  ALUOP_RTYPE = 3'b000,
    parameter logic [ALUOP_W-1:0]  ALUOP_ADDI  = 3'b010,
    parameter logic [ALUOP_W-1:0]  ALUOP_SUB   = 3'b001,
    parameter logic [ALUOP_W-1:0]  ALUOP_ADD   = 3'b011
) (
    input logic                      clk,
    input logic                      rst_n,
    multicycle_control_unit_if.master bus
);

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StFetch   = 4'd1,
        StDecode  = 4'd2,
        StMemAddr = 4'd3,
        StMemRd   = 4'd4,
        StMemWb   = 4'd5,
        StMemWr   = 4'd6,
        StExec    = 4'd7,
        StAluWb   = 4'd8,
        StBranch  = 4'd9
    } state_e;

    typedef struct packed {
        logic               pc_write_cond;
        logic               i_or_d;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               reg_dst;
        logic               reg_write;
        logic               alu_src_a;
        logic [1:0]         alu_src_b;
        logic [1:0]         pc_source;
        logic [ALUOP_W-1:0] alu_op;
        logic               done;
    } ctrl_t;

    state_e           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] instr_count_q;

    logic is_rtype, is_mem, is_alu, is_beq, is_legal, instr_done;

    assign is_rtype = (bus.opcode == OP_RTYPE);
    assign is_mem   = (bus.opcode == OP_LW) || (bus.opcode == OP_SW);
    assign is_alu   = is_rtype || (bus.opcode == OP_ADDI) ||
                      ((bus.opcode >= OP_IALU_LO) && (bus.opcode <= OP_IALU_HI));
    assign is_beq   = (bus.opcode == OP_BEQ);
    assign is_legal = is_mem || is_alu || is_beq;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    state_d = StFetch;
            StFetch:   state_d = bus.mem_ready ? StDecode : StFetch;
            StDecode: begin
                if (is_mem)      state_d = StMemAddr;
                else if (is_alu) state_d = StExec;
                else if (is_beq) state_d = StBranch;
                else             state_d = StFetch;
            end
            StMemAddr: state_d = (bus.opcode == OP_LW) ? StMemRd : StMemWr;
            StMemRd:   state_d = bus.mem_ready ? StMemWb : StMemRd;
            StMemWb:   state_d = StFetch;
            StMemWr:   state_d = bus.mem_ready ? StFetch : StMemWr;
            StExec:    state_d = StAluWb;
            StAluWb:   state_d = StFetch;
            StBranch:  state_d = StFetch;
            default:   state_d = StIdle;
        endcase
    end

    // Moore outputs are decoded from the next state so they come straight out of flops;
    // the opcode is already valid whenever state_d depends on it.
    always_comb begin
        ctrl_d        = '0;
        ctrl_d.alu_op = ALUOP_ADD;
        unique case (state_d)
            StIdle:    ctrl_d.alu_op = '0;
            StFetch: begin
                ctrl_d.mem_read  = 1'b1;
                ctrl_d.alu_src_b = 2'b01;
            end
            StDecode:  ctrl_d.alu_src_b = 2'b11;
            StMemAddr: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = 2'b10;
            end
            StMemRd: begin
                ctrl_d.mem_read = 1'b1;
                ctrl_d.i_or_d   = 1'b1;
            end
            StMemWb: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.done       = 1'b1;
            end
            StMemWr: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.i_or_d    = 1'b1;
            end
            StExec: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = is_rtype ? 2'b00 : 2'b10;
                if (is_rtype)                     ctrl_d.alu_op = ALUOP_RTYPE;
                else if (bus.opcode == OP_ADDI)   ctrl_d.alu_op = ALUOP_ADDI;
                else                              ctrl_d.alu_op = ALUOP_ADD;
            end
            StAluWb: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dst   = is_rtype;
                ctrl_d.done      = 1'b1;
            end
            StBranch: begin
                ctrl_d.alu_src_a     = 1'b1;
                ctrl_d.alu_op        = ALUOP_SUB;
                ctrl_d.pc_write_cond = 1'b1;
                ctrl_d.pc_source     = 2'b01;
                ctrl_d.done          = 1'b1;
            end
            default: ctrl_d.alu_op = '0;
        endcase
    end

    // SW retires on its memory-ready cycle, so that completion cannot be registered early.
    assign instr_done = ctrl_q.done || ((state_q == StMemWr) && bus.mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            ctrl_q        <= '0;
            instr_count_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            if (instr_done) instr_count_q <= instr_count_q + CNT_W'(1);
        end
    end

    assign bus.pc_write      = (state_q == StFetch) && bus.mem_ready;
    assign bus.ir_write      = (state_q == StFetch) && bus.mem_ready;
    assign bus.pc_write_cond = ctrl_q.pc_write_cond;
    assign bus.i_or_d        = ctrl_q.i_or_d;
    assign bus.mem_read      = ctrl_q.mem_read;
    assign bus.mem_write     = ctrl_q.mem_write;
    assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
    assign bus.reg_dst       = ctrl_q.reg_dst;
    assign bus.reg_write     = ctrl_q.reg_write;
    assign bus.alu_src_a     = ctrl_q.alu_src_a;
    assign bus.alu_src_b     = ctrl_q.alu_src_b;
    assign bus.pc_source     = ctrl_q.pc_source;
    assign bus.alu_op        = ctrl_q.alu_op;
    assign bus.state         = state_q;
    assign bus.illegal_op    = (state_q == StDecode) && !is_legal;
    assign bus.instr_done    = instr_done;
    assign bus.instr_count   = instr_count_q;

endmodule
